// File: rtl/dm_ext.sv
// dm_ext: MEM-stage data memory with word/half/byte access,
// sign/zero extension, exception detection and optional wait states.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req, we, op       access request, store enable, size/sign code
//   addr, wdata, pc   byte address, store data, PC for the store log
//   rdata             extended load data (0 unless a good load completes)
//   ready             access completes this cycle
//   exc               misaligned, out-of-range or illegal-op access
module dm_ext #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3072,
    parameter int LATENCY    = 0,
    parameter int LOG_EN     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        exc
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [3:0] CNT_INIT =
        4'(LATENCY > 0 ? LATENCY - 1 : 0);

    logic [31:0] r_mem [DEPTH];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic        w_oor;
    logic        w_hi_set;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_signed;
    logic        w_illegal;
    logic        w_misal;
    logic        w_commit;
    logic [31:0] w_word;
    logic [31:0] w_merged;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Address decode and exception detection
    assign w_idx    = addr[ADDR_WIDTH+1:2];
    assign w_hi_set = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_oor    = w_hi_set | (32'(w_idx) >= 32'(DEPTH));

    always_comb begin
        w_is_word = 1'b0;
        w_is_half = 1'b0;
        w_is_byte = 1'b0;
        w_signed  = 1'b0;
        w_illegal = 1'b0;
        case (op)
            3'b000: w_is_word = 1'b1;
            3'b001: w_is_half = 1'b1;
            3'b010: begin
                w_is_half = 1'b1;
                w_signed  = 1'b1;
            end
            3'b011: w_is_byte = 1'b1;
            3'b100: begin
                w_is_byte = 1'b1;
                w_signed  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_misal = (w_is_word & (addr[1:0] != 2'b00))
                   | (w_is_half & addr[0]);
    assign exc     = req & (w_misal | w_oor | w_illegal);

    // Out-of-range indices never touch the array
    assign w_word = w_oor ? 32'd0 : r_mem[w_idx];
    assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_byte = w_word[{addr[1:0], 3'b000} +: 8];

    // Store merge: untouched lanes keep the old word
    always_comb begin
        w_merged = w_word;
        if (w_is_byte)
            w_merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        else if (w_is_half)
            w_merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        else
            w_merged = wdata;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (req && (LATENCY != 0)) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = req & ((LATENCY == 0)
              | ((r_state == S_WAIT) & (r_cnt == 4'd0)));
        rdata = 32'd0;
        if (ready && !we && !exc) begin
            if (w_is_word)
                rdata = w_word;
            else if (w_is_half)
                rdata = {{16{w_signed & w_half[15]}}, w_half};
            else
                rdata = {{24{w_signed & w_byte[7]}}, w_byte};
        end
    end

    assign w_commit = req & we & ready & ~exc;

    // Memory array; reset wins over a simultaneous store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= 32'd0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
            if (LOG_EN != 0)
                $display("%0d@%08h: *%08h <= %08h", $time, pc,
                         {addr[31:2], 2'b00}, w_merged);
        end
    end

endmodule
